// File: rtl/pipeline_registers_elastic.sv
// Elastic N-stage register pipeline: valid/ready flow control, bubble collapse, flush, masked set.
// Define PIPELINE_REGISTERS_OCCUPANCY_EN to add a registered valid-stage count on `occupancy`.
module pipeline_registers_elastic #(
  parameter int unsigned BIT_WIDTH        = 8,
  parameter int unsigned NUMBER_OF_STAGES = 4
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [BIT_WIDTH-1:0]                  in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [BIT_WIDTH-1:0]                  out_data,
  input  logic                                  set,
  input  logic [BIT_WIDTH*NUMBER_OF_STAGES-1:0] set_data,
  input  logic [NUMBER_OF_STAGES-1:0]           set_valid,
  input  logic                                  flush
`ifdef PIPELINE_REGISTERS_OCCUPANCY_EN
  ,
  output logic [$clog2(NUMBER_OF_STAGES+1)-1:0] occupancy
`endif
);

  localparam int N = int'(NUMBER_OF_STAGES);
  localparam int W = int'(BIT_WIDTH);

  logic [N-1:0]        valid_q, valid_d;
  logic [N-1:0][W-1:0] data_q, data_d;
  logic [N-1:0]        en;
  logic [N-1:0]        prev_valid;
  logic [N-1:0][W-1:0] prev_data;
  logic                blocked;

  assign blocked = flush | set;

  // Advance enable ripples from the output back to the input; an empty stage always accepts.
  always_comb begin
    en = '0;
    en[N-1] = ~valid_q[N-1] | out_ready;
    for (int i = N - 2; i >= 0; i--) begin
      en[i] = ~valid_q[i] | en[i+1];
    end
  end

  always_comb begin
    prev_valid    = '0;
    prev_data     = '0;
    prev_valid[0] = in_valid;
    prev_data[0]  = in_data;
    for (int i = 1; i < N; i++) begin
      prev_valid[i] = valid_q[i-1];
      prev_data[i]  = data_q[i-1];
    end
  end

  assign in_ready  = en[0] & ~blocked;
  assign out_valid = valid_q[N-1] & ~blocked;
  assign out_data  = data_q[N-1];

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = '0;
    end else if (set) begin
      valid_d = set_valid;
      for (int i = 0; i < N; i++) begin
        data_d[i] = set_data[W*i +: W];
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (en[i]) begin
          valid_d[i] = prev_valid[i];
          // Data only moves with a valid word so idle stages keep their last contents.
          if (prev_valid[i]) begin
            data_d[i] = prev_data[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

`ifdef PIPELINE_REGISTERS_OCCUPANCY_EN
  localparam int OccW = $clog2(NUMBER_OF_STAGES + 1);

  logic [OccW-1:0] occ_q, occ_d;
  logic [OccW-1:0] set_count;
  logic            in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    set_count = '0;
    for (int i = 0; i < N; i++) begin
      set_count = set_count + OccW'(set_valid[i]);
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (set) begin
      occ_d = set_count;
    end else if (in_xfer && !out_xfer) begin
      occ_d = occ_q + OccW'(1);
    end else if (out_xfer && !in_xfer) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipeline_registers_elastic.sv
// Scoreboard bench for pipeline_registers_elastic: reset, stream, backpressure, set, flush.
module tb_pipeline_registers_elastic;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]   in_data, out_data;
  logic           set, flush;
  logic [W*N-1:0] set_data;
  logic [N-1:0]   set_valid;
`ifdef PIPELINE_REGISTERS_OCCUPANCY_EN
  logic [$clog2(N+1)-1:0] occupancy;
`endif

  pipeline_registers_elastic #(
    .BIT_WIDTH       (W),
    .NUMBER_OF_STAGES(N)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .set      (set),
    .set_data (set_data),
    .set_valid(set_valid),
    .flush    (flush)
`ifdef PIPELINE_REGISTERS_OCCUPANCY_EN
    ,
    .occupancy(occupancy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    int           acc;
    bit           lat;
  } item_t;

  item_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Output monitor: a transfer seen at the negedge completes on the following rising edge.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        item_t it;
        it = sb.pop_front();
        check_eq("out_data", 32'(out_data), 32'(it.d));
        if (it.lat) check_eq("latency", 32'(cyc - it.acc), 32'(N - 1));
      end
    end
  end

  task automatic send_word(input logic [W-1:0] d, input bit lat);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 50) check_eq("in_timeout", 32'(in_ready), 32'd1);
    else sb.push_back('{d: d, acc: cyc + 1, lat: lat});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    set       = 1'b0;
    flush     = 1'b0;
    set_data  = '0;
    set_valid = '0;
    idle(2);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    reset_n = 1'b1;
    idle(1);

    // Reset mid-stream
    out_ready = 1'b0;
    send_word(8'h55, 1'b0);
    send_word(8'h66, 1'b0);
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_out_data", 32'(out_data), 32'd0);
    idle(1);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_out_valid2", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    idle(1);

    // Stream at full throughput; the monitor checks order and N-1 latency
    for (int i = 0; i < 8; i++) send_word(8'h10 + 8'(i), 1'b1);
    idle(8);
    check_eq("stream_drained", 32'(sb.size()), 32'd0);

    // Backpressure: fill while stalled
    out_ready = 1'b0;
    send_word(8'hA3, 1'b0);
    send_word(8'hA2, 1'b0);
    send_word(8'hA1, 1'b0);
    send_word(8'hA0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    @(negedge clk);
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    check_eq("full_out_valid", 32'(out_valid), 32'd1);
    check_eq("full_out_data", 32'(out_data), 32'hA3);
    idle(3);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("full_hold_data", 32'(out_data), 32'hA3);
    check_eq("full_hold_ready", 32'(in_ready), 32'd0);
    idle(1);
    out_ready = 1'b1;
    idle(8);
    check_eq("bp_drained", 32'(sb.size()), 32'd0);
    check_eq("bp_empty_valid", 32'(out_valid), 32'd0);

    // Masked set with a bubble at stage 2
    out_ready = 1'b0;
    set       = 1'b1;
    set_data  = {8'h67, 8'h45, 8'h23, 8'h01};
    set_valid = 4'b1011;
    @(negedge clk);
    check_eq("set_in_ready", 32'(in_ready), 32'd0);
    check_eq("set_out_valid", 32'(out_valid), 32'd0);
    sb.push_back('{d: 8'h67, acc: 0, lat: 1'b0});
    sb.push_back('{d: 8'h23, acc: 0, lat: 1'b0});
    sb.push_back('{d: 8'h01, acc: 0, lat: 1'b0});
    @(posedge clk);
    #1;
    set = 1'b0;
    @(negedge clk);
    check_eq("set_out_data", 32'(out_data), 32'h67);
    check_eq("bubble_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPELINE_REGISTERS_OCCUPANCY_EN
    check_eq("occ_after_set", 32'(occupancy), 32'd3);
`endif
    idle(2);
    out_ready = 1'b1;
    idle(8);
    check_eq("set_drained", 32'(sb.size()), 32'd0);

    // Flush with three valid stages
    out_ready = 1'b0;
    send_word(8'hB0, 1'b0);
    send_word(8'hB1, 1'b0);
    send_word(8'hB2, 1'b0);
    idle(1);
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_in_ready", 32'(in_ready), 32'd0);
    check_eq("flush_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    sb.delete();
    #1;
    flush = 1'b0;
    @(negedge clk);
    check_eq("post_flush_valid", 32'(out_valid), 32'd0);
    check_eq("post_flush_ready", 32'(in_ready), 32'd1);
    check_eq("flush_data_hold", 32'(out_data), 32'hB0);

    // Set and flush together: flush wins
    set       = 1'b1;
    flush     = 1'b1;
    set_data  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    set_valid = 4'b1111;
    @(posedge clk);
    #1;
    set   = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check_eq("setflush_valid", 32'(out_valid), 32'd0);
    check_eq("setflush_ready", 32'(in_ready), 32'd1);
    check_eq("setflush_data", 32'(out_data), 32'hB0);
    out_ready = 1'b1;
    idle(6);
    check_eq("setflush_empty", 32'(out_valid), 32'd0);

`ifdef PIPELINE_REGISTERS_OCCUPANCY_EN
    check_eq("occ_empty", 32'(occupancy), 32'd0);
    send_word(8'hD0, 1'b0);
    check_eq("occ_one", 32'(occupancy), 32'd1);
    out_ready = 1'b0;
    idle(3);
    out_ready = 1'b1;
    send_word(8'hD1, 1'b0);
    check_eq("occ_inout", 32'(occupancy), 32'd1);
    out_ready = 1'b0;
    idle(4);
    for (int i = 0; i < 3; i++) send_word(8'hE0 + 8'(i), 1'b0);
    check_eq("occ_full", 32'(occupancy), 32'd4);
    out_ready = 1'b1;
    idle(8);
`endif

    check_eq("sb_leftover", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
